// File: rtl/mdu_sched.sv
`default_nettype none
// ============================================================================
// Module      : mdu_sched
// Description : E-stage multiply/divide sequencer. Owns HI/LO, computes the
//               result at issue into pending registers, and commits it after
//               a fixed latency. Raises the D-stage stall request while an
//               operation is in flight.
//               Optional feature macro: MDU_CANCEL_EN (abort in-flight ops).
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_sched #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        d_mdu_use,
    input  logic        rd_sel,
    input  logic        cancel,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    localparam logic [3:0] c_MULT_LAT = MULT_LAT[3:0];
    localparam logic [3:0] c_DIV_LAT  = DIV_LAT[3:0];

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_count;
    logic [3:0]  w_count_nxt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;
    logic [31:0] w_pend_hi_nxt;
    logic [31:0] w_pend_lo_nxt;

    logic        w_cancel;
    logic        w_issue;
    logic        w_op_arith;
    logic        w_div_zero;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_quot_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_quot_u;
    logic [31:0] w_rem_u;

`ifdef MDU_CANCEL_EN
    assign w_cancel = cancel;
`else
    // Cancel is not supported in this build; the port is kept for a stable interface.
    logic w_unused_cancel;
    assign w_unused_cancel = cancel;
    assign w_cancel        = 1'b0;
`endif

    // Cancel in IDLE suppresses the issue of any op, including mthi/mtlo.
    assign w_issue    = start & ~w_cancel;
    assign w_op_arith = (op >= c_OP_MULT) && (op <= c_OP_DIVU);
    assign w_div_zero = (src_b == 32'd0);

    // Result datapath; both signed and unsigned flavours computed at issue.
    assign w_prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    assign w_prod_u = {32'd0, src_a} * {32'd0, src_b};
    assign w_quot_s = w_div_zero ? 32'd0 : 32'($signed(src_a) / $signed(src_b));
    assign w_rem_s  = w_div_zero ? 32'd0 : 32'($signed(src_a) % $signed(src_b));
    assign w_quot_u = w_div_zero ? 32'd0 : (src_a / src_b);
    assign w_rem_u  = w_div_zero ? 32'd0 : (src_a % src_b);

    // Next-state logic: issue in IDLE, count down in RUN, commit on the last cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    case (op)
                        c_OP_MULT: begin
                            w_pend_hi_nxt = w_prod_s[63:32];
                            w_pend_lo_nxt = w_prod_s[31:0];
                            w_count_nxt   = c_MULT_LAT;
                            w_state_nxt   = RUN;
                        end
                        c_OP_MULTU: begin
                            w_pend_hi_nxt = w_prod_u[63:32];
                            w_pend_lo_nxt = w_prod_u[31:0];
                            w_count_nxt   = c_MULT_LAT;
                            w_state_nxt   = RUN;
                        end
                        c_OP_DIV: begin
                            // Divide by zero re-commits the current HI/LO unchanged.
                            w_pend_hi_nxt = w_div_zero ? r_hi : w_rem_s;
                            w_pend_lo_nxt = w_div_zero ? r_lo : w_quot_s;
                            w_count_nxt   = c_DIV_LAT;
                            w_state_nxt   = RUN;
                        end
                        c_OP_DIVU: begin
                            w_pend_hi_nxt = w_div_zero ? r_hi : w_rem_u;
                            w_pend_lo_nxt = w_div_zero ? r_lo : w_quot_u;
                            w_count_nxt   = c_DIV_LAT;
                            w_state_nxt   = RUN;
                        end
                        c_OP_MTHI: w_hi_nxt = src_a;
                        c_OP_MTLO: w_lo_nxt = src_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Starts while busy are ignored; cancel wins over completion.
                if (w_cancel) begin
                    w_count_nxt = 4'd0;
                    w_state_nxt = IDLE;
                end else if (r_count == 4'd1) begin
                    w_hi_nxt    = r_pend_hi;
                    w_lo_nxt    = r_pend_lo;
                    w_count_nxt = 4'd0;
                    w_state_nxt = IDLE;
                end else begin
                    w_count_nxt = r_count - 4'd1;
                end
            end
            default: begin
                w_count_nxt = 4'd0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and architectural registers; async reset discards any pending result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
        end
    end

    assign busy      = (r_count != 4'd0);
    assign stall_req = d_mdu_use & (busy | (start & w_op_arith));
    assign rd_data   = rd_sel ? r_hi : r_lo;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_sched
// Description : Self-checking bench for mdu_sched. Expected HI/LO/latency are
//               predicted at issue, queued, and compared when busy falls.
//               Honours MDU_CANCEL_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_sched;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        d_mdu_use;
    logic        rd_sel;
    logic        cancel;
    logic [31:0] rd_data;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .d_mdu_use (d_mdu_use),
        .rd_sel    (rd_sel),
        .cancel    (cancel),
        .rd_data   (rd_data),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          n_checks;
    int          n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Reference model: sign-magnitude division, 64-bit products.
    task automatic predict(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input int cancel_at);
        exp_t        e;
        logic [63:0] p;
        logic [31:0] ma, mb, q, r;
        e.hi = m_hi;
        e.lo = m_lo;
        e.lat = (o <= 3'd2) ? MULT_LAT : DIV_LAT;
        case (o)
            3'd1: begin
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            3'd2: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            3'd3: if (b != 0) begin
                ma = a[31] ? -a : a;
                mb = b[31] ? -b : b;
                q = ma / mb;
                r = ma % mb;
                e.lo = (a[31] ^ b[31]) ? -q : q;
                e.hi = a[31] ? -r : r;
            end
            3'd4: if (b != 0) begin
                e.lo = a / b;
                e.hi = a % b;
            end
            default: ;
        endcase
`ifdef MDU_CANCEL_EN
        if (cancel_at != 0) begin
            e.hi = m_hi;
            e.lo = m_lo;
            e.lat = cancel_at;
        end
`endif
        m_hi = e.hi;
        m_lo = e.lo;
        sb_q.push_back(e);
    endtask

    // Issue one mult/div; optionally inject an mtlo or a cancel at a given busy cycle.
    task automatic do_arith(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic use_d, input int inject_at, input int cancel_at);
        exp_t        e;
        int          cyc;
        int          stalls;
        logic [31:0] old_lo;
        @(negedge clk);
        old_lo    = lo;
        start     = 1'b1;
        op        = o;
        src_a     = a;
        src_b     = b;
        d_mdu_use = use_d;
        rd_sel    = 1'b0;
        predict(o, a, b, cancel_at);
        stalls = 0;
        #1;
        if (stall_req) stalls++;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd0;
        cyc   = 0;
        forever begin
            @(negedge clk);
            if (!busy || cyc > 40) break;
            cyc++;
            if (stall_req) stalls++;
            if (cyc == 1) check("no_forward", rd_data, old_lo);
            if (cyc == inject_at) begin
                start = 1'b1; op = 3'd6; src_a = 32'h99;
            end else begin
                start = 1'b0; op = 3'd0;
            end
            cancel = (cyc == cancel_at);
        end
        start  = 1'b0;
        op     = 3'd0;
        cancel = 1'b0;
        e = sb_q.pop_front();
        check("busy_len", 32'(cyc), 32'(e.lat));
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("stall_len", 32'(stalls), use_d ? 32'(e.lat + 1) : 32'd0);
        #1;
        check("stall_after", {31'd0, stall_req}, 32'd0);
        d_mdu_use = 1'b0;
    endtask

    // mthi/mtlo followed by a read of the written register the next cycle.
    task automatic do_mt(input logic [2:0] o, input logic [31:0] a);
        @(negedge clk);
        start     = 1'b1;
        op        = o;
        src_a     = a;
        d_mdu_use = 1'b1;
        #1;
        check("mt_stall_issue", {31'd0, stall_req}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'd0;
        if (o == 3'd5) m_hi = a; else m_lo = a;
        @(negedge clk);
        rd_sel = (o == 3'd5);
        #1;
        check("mt_busy", {31'd0, busy}, 32'd0);
        check("mt_stall", {31'd0, stall_req}, 32'd0);
        check("mf_rd_data", rd_data, a);
        d_mdu_use = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        m_hi      = 32'd0;
        m_lo      = 32'd0;
        reset     = 1'b1;
        start     = 1'b0;
        op        = 3'd0;
        src_a     = 32'd0;
        src_b     = 32'd0;
        d_mdu_use = 1'b0;
        rd_sel    = 1'b0;
        cancel    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b0;

        do_arith(3'd1, 32'd3, 32'hFFFFFFFE, 1'b1, 0, 0);
        check("mult_hi_const", hi, 32'hFFFFFFFF);
        check("mult_lo_const", lo, 32'hFFFFFFFA);
        do_arith(3'd4, 32'd7, 32'd2, 1'b0, 0, 0);
        do_arith(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 0, 0);
        check("div_lo_const", lo, 32'hFFFFFFFD);
        do_arith(3'd2, 32'hFFFFFFFF, 32'h80000001, 1'b1, 0, 0);
        do_arith(3'd3, 32'd100, 32'hFFFFFFF9, 1'b0, 0, 0);

        do_mt(3'd6, 32'h1234);
        do_mt(3'd5, 32'hAA);
        do_mt(3'd6, 32'hBB);
        do_arith(3'd3, 32'd55, 32'd0, 1'b1, 0, 0);
        check("div0_hi", hi, 32'hAA);
        do_arith(3'd1, 32'd6, 32'd7, 1'b0, 2, 0);

        do_mt(3'd5, 32'h55);
        do_arith(3'd1, 32'd3, 32'd4, 1'b0, 0, 2);

        do_mt(3'd5, 32'hAA);
        do_mt(3'd6, 32'hBB);
        @(negedge clk);
        start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_lo", lo, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
